spi_sram_sync_model: RTL and testbench

- Parametrised, clock-synchronous successor to the behavioural SPI SRAM model used in the CPU testbench; models a 23LC-class serial SRAM.
- Oversamples the SPI pins with the system clock, so it is synthesizable and FPGA-emulatable alongside the CPU.
- Adds configurable address width and depth, a mode register (byte/page/sequential) with wrap rules, and a backdoor load/peek port for test preload.

---
 rtl/spi_sram_sync_model.sv | 203 ++++++++++++++++++++
 tb/tb_spi_sram_sync_model.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_sync_model.sv
// Clock-synchronous 23LC-class serial SRAM model: SPI pins oversampled on clk,
// byte/page/sequential mode register, plus a backdoor load/peek port.
module spi_sram_sync_model #(
  parameter int         ADDR_BYTES  = 2,
  parameter int         MEM_DEPTH   = 256,
  parameter int         PAGE_SIZE   = 32,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] MODE_RESET  = 2'b01
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_cs_n,
  input  logic                         spi_sclk,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata,
  output logic                         busy,
  output logic [1:0]                   mode
);
  localparam int            AW             = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PMASK          = AW'(PAGE_SIZE - 1);
  localparam logic [1:0]    LAST_ADDR_BYTE = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA_RD, S_DATA_WR, S_MODE_RD, S_MODE_WR, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_s, sclk_s, mosi_s, cs_q, sclk_q;
  logic sclk_rise, sclk_fall, cs_fall, byte_done;

  logic [7:0]    mem [MEM_DEPTH];
  logic [7:0]    shreg, rx_byte, out_sh;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] addr, addr_acc, addr_shift, addr_inc, addr_adv;
  logic          is_rd;

  logic          mem_we, addr_ld, out_ld, mode_ld, rd_ld, rd_val;
  logic [AW-1:0] addr_val;
  logic [7:0]    out_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync[0]   <= spi_cs_n;
      sclk_sync[0] <= spi_sclk;
      mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      cs_q   <= cs_s;
      sclk_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign rx_byte   = {shreg[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_s;

  assign addr_shift = (addr_acc << 8) | AW'(rx_byte);
  assign addr_inc   = addr + AW'(1);
  // Page mode keeps the upper address bits and wraps only the in-page offset.
  assign addr_adv   = (mode == 2'b10) ? ((addr & ~PMASK) | (addr_inc & PMASK)) : addr_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    addr_ld   = 1'b0;
    addr_val  = addr;
    out_ld    = 1'b0;
    out_val   = out_sh;
    mode_ld   = 1'b0;
    rd_ld     = 1'b0;
    rd_val    = is_rd;
    if (cs_s) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) state_nxt = S_CMD;
        S_CMD: if (byte_done) begin
          case (rx_byte)
            8'h03: begin state_nxt = S_ADDR; rd_ld = 1'b1; rd_val = 1'b1; end
            8'h02: begin state_nxt = S_ADDR; rd_ld = 1'b1; rd_val = 1'b0; end
            8'h05: begin state_nxt = S_MODE_RD; out_ld = 1'b1; out_val = {mode, 6'b0}; end
            8'h01: state_nxt = S_MODE_WR;
            default: state_nxt = S_IGNORE;
          endcase
        end
        S_ADDR: if (byte_done && byte_cnt == LAST_ADDR_BYTE) begin
          addr_ld  = 1'b1;
          addr_val = addr_shift;
          if (is_rd) begin
            state_nxt = S_DATA_RD;
            out_ld    = 1'b1;
            out_val   = mem[addr_shift];
          end else begin
            state_nxt = S_DATA_WR;
          end
        end
        S_DATA_RD: if (byte_done) begin
          out_ld = 1'b1;
          if (mode == 2'b00) begin
            state_nxt = S_IGNORE;
            out_val   = 8'h00;
          end else begin
            addr_ld  = 1'b1;
            addr_val = addr_adv;
            out_val  = mem[addr_adv];
          end
        end
        S_DATA_WR: if (byte_done) begin
          mem_we = 1'b1;
          if (mode == 2'b00) state_nxt = S_IGNORE;
          else begin
            addr_ld  = 1'b1;
            addr_val = addr_adv;
          end
        end
        S_MODE_RD: if (byte_done) begin
          out_ld  = 1'b1;
          out_val = {mode, 6'b0};
        end
        S_MODE_WR: if (byte_done) begin
          mode_ld   = 1'b1;
          state_nxt = S_IGNORE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_RESET;
      out_sh   <= 8'h00;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      addr     <= '0;
      addr_acc <= '0;
      is_rd    <= 1'b0;
    end else begin
      if (mode_ld) mode <= rx_byte[7:6];
      if (addr_ld) addr <= addr_val;
      if (rd_ld)   is_rd <= rd_val;
      if (cs_s) begin
        out_sh   <= 8'h00;
        shreg    <= 8'h00;
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
      end else begin
        if (sclk_rise) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // No shift on the fall after the 8th rise: the fresh byte's MSB is already out.
        if (out_ld)                              out_sh <= out_val;
        else if (sclk_fall && bit_cnt != 3'd0)   out_sh <= out_sh << 1;
        if (byte_done && state == S_ADDR) begin
          addr_acc <= addr_shift;
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

  // Backdoor write is last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr] <= rx_byte;
    if (bd_we)          mem[bd_addr] <= bd_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) bd_rdata <= 8'h00;
    else     bd_rdata <= mem[bd_addr];
  end

  assign spi_miso = ((state == S_DATA_RD) || (state == S_MODE_RD)) && out_sh[7];
  assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_spi_sram_sync_model.sv
// Randomised scoreboard bench: a byte-level SRAM model predicts every MISO byte;
// a monitor on the SPI pins pops and compares each received byte.
module tb_spi_sram_sync_model;
  localparam int HALF = 5;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, spi_cs_n, spi_sclk, spi_mosi, spi_miso, bd_we, busy;
  logic [7:0] bd_addr, bd_wdata, bd_rdata;
  logic [1:0] mode;

  always #5 clk = ~clk;

  spi_sram_sync_model dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .busy(busy), .mode(mode)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] m_mem [256];
  logic [1:0] m_mode;
  logic [7:0] exp_q [$];
  logic [7:0] dat [8];
  logic [7:0] mon_sh, mon_exp;
  int         mon_cnt;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) mon_cnt = 0;
    else begin
      mon_sh = {mon_sh[6:0], spi_miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL miso_unexpected: got %02h, required no byte", mon_sh);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("miso_byte", int'(mon_sh), int'(mon_exp));
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = b[i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("busy_after_cs", int'(busy), 0);
    chk("mode_reg", int'(mode), int'(m_mode));
    repeat (HALF) @(negedge clk);
  endtask

  task automatic bd_write(input int a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a[7:0]; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
    m_mem[a[7:0]] = d;
  endtask

  task automatic peek(input int a, input string nm);
    @(negedge clk);
    bd_addr = a[7:0];
    @(negedge clk);
    chk(nm, int'(bd_rdata), int'(m_mem[a[7:0]]));
  endtask

  function automatic int adv(input int a);
    if (m_mode == 2'b10) return (a / 32) * 32 + ((a + 1) % 32);
    return (a + 1) % 256;
  endfunction

  // Whole transaction: model predicts MISO bytes and memory/mode effects up front.
  task automatic txn(input logic [7:0] cmd, input int addr, input int n);
    logic [7:0] tx [$];
    logic [15:0] a16;
    int a;
    bit ign;
    a16 = addr[15:0];
    tx.push_back(cmd); exp_q.push_back(8'h00);
    if (cmd == 8'h03 || cmd == 8'h02) begin
      tx.push_back(a16[15:8]); exp_q.push_back(8'h00);
      tx.push_back(a16[7:0]);  exp_q.push_back(8'h00);
    end
    a = addr % 256;
    ign = 1'b0;
    for (int i = 0; i < n; i++) begin
      tx.push_back(dat[i]);
      case (cmd)
        8'h03: begin
          exp_q.push_back(ign ? 8'h00 : m_mem[a]);
          if (m_mode == 2'b00) ign = 1'b1; else a = adv(a);
        end
        8'h02: begin
          exp_q.push_back(8'h00);
          if (!ign) begin
            m_mem[a] = dat[i];
            if (m_mode == 2'b00) ign = 1'b1; else a = adv(a);
          end
        end
        8'h05: exp_q.push_back({m_mode, 6'b0});
        8'h01: begin
          exp_q.push_back(8'h00);
          if (i == 0) m_mode = dat[i][7:6];
        end
        default: exp_q.push_back(8'h00);
      endcase
    end
    cs_lo();
    foreach (tx[k]) begin
      spi_bits(tx[k], 8);
      if (k == 0) chk("busy_active", int'(busy), 1);
    end
    cs_hi();
  endtask

  initial begin
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    bd_we = 1'b0; bd_addr = 8'h00; bd_wdata = 8'h00;
    m_mode = 2'b01;
    repeat (4) @(negedge clk);
    chk("rst_miso", int'(spi_miso), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mode", int'(mode), 1);
    chk("rst_bd_rdata", int'(bd_rdata), 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) bd_write(i, 8'($urandom));

    bd_write(8'h10, 8'hA1); bd_write(8'h11, 8'hB2);
    bd_write(8'h12, 8'hC3); bd_write(8'h13, 8'hD4);
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    txn(8'h03, 16'h0010, 4);

    bd_write(8'hFF, 8'h5A); bd_write(8'h00, 8'h6B);
    txn(8'h03, 16'h00FF, 2);

    dat[0] = 8'h80;
    txn(8'h01, 0, 1);
    dat[0] = 8'h11; dat[1] = 8'h22;
    txn(8'h02, 16'h001F, 2);
    peek(8'h1F, "page_wr_1f"); peek(8'h00, "page_wr_00"); peek(8'h20, "page_wr_20");
    dat[0] = 8'h00;
    txn(8'h05, 0, 1);

    dat[0] = 8'h00;
    txn(8'h01, 0, 1);
    dat[0] = 8'h77; dat[1] = 8'h88;
    txn(8'h02, 16'h0040, 2);
    peek(8'h40, "byte_wr_40"); peek(8'h41, "byte_wr_41");
    txn(8'h03, 16'h0040, 2);

    // Write aborted after 5 data bits must leave memory alone.
    cs_lo();
    repeat (3) exp_q.push_back(8'h00);
    spi_bits(8'h02, 8); spi_bits(8'h00, 8); spi_bits(8'h50, 8); spi_bits(8'hFF, 5);
    cs_hi();
    peek(8'h50, "abort_wr_50");
    txn(8'h03, 16'h0050, 1);

    dat[0] = 8'h5C; dat[1] = 8'hE7;
    txn(8'hFF, 0, 2);
    peek(8'h50, "unknown_cmd_mem");

    // Reset in the middle of a read of D4 while MISO is high.
    dat[0] = 8'h80;
    txn(8'h01, 0, 1);
    cs_lo();
    repeat (3) exp_q.push_back(8'h00);
    spi_bits(8'h03, 8); spi_bits(8'h00, 8); spi_bits(8'h13, 8); spi_bits(8'h00, 3);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_mode", int'(mode), 1);
    chk("midrst_miso", int'(spi_miso), 0);
    chk("midrst_busy", int'(busy), 0);
    m_mode = 2'b01;
    rst = 1'b0;
    cs_hi();

    for (int t = 0; t < 30; t++) begin
      int sel;
      logic [7:0] cmd;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: cmd = 8'h03;
        2, 3: cmd = 8'h02;
        4:    cmd = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h01;
        default: cmd = 8'($urandom);
      endcase
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) bd_write($urandom_range(0, 255), 8'($urandom));
      txn(cmd, $urandom_range(0, 65535), $urandom_range(1, 4));
    end

    for (int i = 0; i < 256; i++) peek(i, "final_mem");
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
